// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status byte constants, receive state encoding and
// the per-status data-byte count used by the input parser and seq_trigger.
package midi_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [7:0] NOTE_OFF   = 8'h80;
  localparam logic [7:0] NOTE_ON    = 8'h90;
  localparam logic [7:0] POLY_AT    = 8'hA0;
  localparam logic [7:0] CTRL_CHG   = 8'hB0;
  localparam logic [7:0] PROG_CHG   = 8'hC0;
  localparam logic [7:0] CHAN_AT    = 8'hD0;
  localparam logic [7:0] PITCH_BEND = 8'hE0;
  localparam logic [7:0] SYX_START  = 8'hF0;
  localparam logic [7:0] MTC_QF     = 8'hF1;
  localparam logic [7:0] SONG_POS   = 8'hF2;
  localparam logic [7:0] SONG_SEL   = 8'hF3;
  localparam logic [7:0] TUNE_REQ   = 8'hF6;
  localparam logic [7:0] SYX_END    = 8'hF7;
  localparam logic [7:0] RT_MIN     = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHAN   = 2'd1,
    ST_SYSEX  = 2'd2,
    ST_SYSCOM = 2'd3
  } midi_rx_state_t;

  // Number of data bytes following a status byte (0 for anything without data).
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_in_parser.sv
// MIDI byte stream parser: running status tracking, message byte numbering,
// channel/SysEx qualification, and real-time byte split-off.
module midi_in_parser
  import midi_pkg::*;
#(
  parameter bit         OMNI       = 1'b0,
  parameter logic [7:0] SYX_NR_MAX = 8'hFF
) (
  input  logic              reg_clk,
  input  logic              reset_reg,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic [3:0]        midi_ch,
  output logic              byteready,
  output logic [BYTE_W-1:0] midi_in_data,
  output logic [BYTE_W-1:0] midibyte_nr,
  output logic              is_cur_midi_ch,
  output logic              is_st_sysex,
  output logic              syx_end,
  output logic              rt_valid,
  output logic [BYTE_W-1:0] rt_byte,
  output logic              drop
);

  midi_rx_state_t    state_q, state_d;
  logic [BYTE_W-1:0] run_st_q, run_st_d;
  logic [BYTE_W-1:0] cnt_q, cnt_d;

  logic              byteready_d, syx_end_d, rt_valid_d, drop_d;
  logic [BYTE_W-1:0] data_d, nr_d, rt_byte_d;
  logic              cur_d, sysex_d;

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      state_q  <= ST_IDLE;
      run_st_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_st_q <= run_st_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state and next output values; outputs hold unless a byte updates them.
  always_comb begin
    state_d     = state_q;
    run_st_d    = run_st_q;
    cnt_d       = cnt_q;
    byteready_d = 1'b0;
    syx_end_d   = 1'b0;
    rt_valid_d  = 1'b0;
    drop_d      = 1'b0;
    data_d      = midi_in_data;
    nr_d        = midibyte_nr;
    cur_d       = is_cur_midi_ch;
    sysex_d     = is_st_sysex;
    rt_byte_d   = rt_byte;

    if (rx_valid) begin
      if (rx_byte >= RT_MIN) begin
        rt_valid_d = 1'b1;
        rt_byte_d  = rx_byte;
      end else if (rx_byte[7]) begin
        if (rx_byte == SYX_END) begin
          // A stray F7 outside SysEx is ignored entirely.
          if (state_q == ST_SYSEX) begin
            byteready_d = 1'b1;
            syx_end_d   = 1'b1;
            data_d      = rx_byte;
            nr_d        = '0;
            cur_d       = 1'b0;
            sysex_d     = 1'b1;
            state_d     = ST_IDLE;
            run_st_d    = '0;
            cnt_d       = '0;
          end
        end else begin
          syx_end_d = (state_q == ST_SYSEX);
          run_st_d  = '0;
          cnt_d     = '0;
          if (rx_byte < SYX_START) begin
            byteready_d = 1'b1;
            data_d      = rx_byte;
            nr_d        = '0;
            cur_d       = OMNI || (rx_byte[3:0] == midi_ch);
            sysex_d     = 1'b0;
            run_st_d    = rx_byte;
            state_d     = ST_CHAN;
          end else if (rx_byte == SYX_START) begin
            byteready_d = 1'b1;
            data_d      = rx_byte;
            nr_d        = '0;
            cur_d       = 1'b0;
            sysex_d     = 1'b1;
            state_d     = ST_SYSEX;
          end else begin
            // System common: cnt holds the number of data bytes still to swallow.
            cur_d   = 1'b0;
            sysex_d = 1'b0;
            cnt_d   = BYTE_W'(midi_data_len(rx_byte));
            state_d = (midi_data_len(rx_byte) != 2'd0) ? ST_SYSCOM : ST_IDLE;
          end
        end
      end else begin
        case (state_q)
          ST_CHAN: begin
            cnt_d       = (cnt_q >= BYTE_W'(midi_data_len(run_st_q))) ? BYTE_W'(1) : cnt_q + BYTE_W'(1);
            byteready_d = 1'b1;
            data_d      = rx_byte;
            nr_d        = cnt_d;
            cur_d       = OMNI || (run_st_q[3:0] == midi_ch);
            sysex_d     = 1'b0;
          end
          ST_SYSEX: begin
            cnt_d       = (cnt_q >= SYX_NR_MAX) ? cnt_q : cnt_q + BYTE_W'(1);
            byteready_d = 1'b1;
            data_d      = rx_byte;
            nr_d        = cnt_d;
            cur_d       = 1'b0;
            sysex_d     = 1'b1;
          end
          ST_SYSCOM: begin
            if (cnt_q <= BYTE_W'(1)) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q - BYTE_W'(1);
            end
          end
          default: drop_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      byteready      <= 1'b0;
      midi_in_data   <= '0;
      midibyte_nr    <= '0;
      is_cur_midi_ch <= 1'b0;
      is_st_sysex    <= 1'b0;
      syx_end        <= 1'b0;
      rt_valid       <= 1'b0;
      rt_byte        <= '0;
      drop           <= 1'b0;
    end else begin
      byteready      <= byteready_d;
      midi_in_data   <= data_d;
      midibyte_nr    <= nr_d;
      is_cur_midi_ch <= cur_d;
      is_st_sysex    <= sysex_d;
      syx_end        <= syx_end_d;
      rt_valid       <= rt_valid_d;
      rt_byte        <= rt_byte_d;
      drop           <= drop_d;
    end
  end

endmodule

// File: tb/tb_midi_in_parser.sv
// Directed scoreboard bench for midi_in_parser; a second instance with OMNI=1
// runs on the same stimulus to check omni channel qualification.
module tb_midi_in_parser;

  logic       reg_clk = 1'b0;
  logic       reset_reg = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [3:0] midi_ch = 4'd0;

  logic       byteready, is_cur, is_syx, syx_end, rt_valid, drop;
  logic [7:0] data, nr, rt_byte;
  logic       o_byteready, o_is_cur, o_is_syx, o_syx_end, o_rt_valid, o_drop;
  logic [7:0] o_data, o_nr, o_rt_byte;

  always #5 reg_clk = ~reg_clk;

  midi_in_parser #(.OMNI(1'b0), .SYX_NR_MAX(8'hFF)) dut (
    .reg_clk(reg_clk), .reset_reg(reset_reg), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .midi_ch(midi_ch), .byteready(byteready), .midi_in_data(data), .midibyte_nr(nr),
    .is_cur_midi_ch(is_cur), .is_st_sysex(is_syx), .syx_end(syx_end),
    .rt_valid(rt_valid), .rt_byte(rt_byte), .drop(drop));

  midi_in_parser #(.OMNI(1'b1), .SYX_NR_MAX(8'hFF)) dut_omni (
    .reg_clk(reg_clk), .reset_reg(reset_reg), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .midi_ch(midi_ch), .byteready(o_byteready), .midi_in_data(o_data), .midibyte_nr(o_nr),
    .is_cur_midi_ch(o_is_cur), .is_st_sysex(o_is_syx), .syx_end(o_syx_end),
    .rt_valid(o_rt_valid), .rt_byte(o_rt_byte), .drop(o_drop));

  typedef struct {
    logic       br;
    logic [7:0] data;
    logic [7:0] nr;
    logic       cur;
    logic       cur_o;
    logic       syx;
    logic       se;
    logic       rt;
    logic [7:0] rtb;
    logic       drop;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] ch_sel = 4'd0;
  logic [7:0] last_data = 8'h00, last_nr = 8'h00, last_rt = 8'h00;
  logic       last_cur = 1'b0, last_cur_o = 1'b0, last_syx = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge reg_clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    midi_ch  = ch_sel;
  endtask

  task automatic idle();
    @(negedge reg_clk);
    rx_valid = 1'b0;
  endtask

  task automatic push(input logic br, input logic se, input logic rt, input logic dr);
    exp_t e;
    e.br = br; e.data = last_data; e.nr = last_nr; e.cur = last_cur; e.cur_o = last_cur_o;
    e.syx = last_syx; e.se = se; e.rt = rt; e.rtb = last_rt; e.drop = dr;
    sb.push_back(e);
  endtask

  task automatic send_emit(input logic [7:0] b, input logic [7:0] n, input logic cur,
                           input logic cur_o, input logic syx, input logic se);
    last_data = b; last_nr = n; last_cur = cur; last_cur_o = cur_o; last_syx = syx;
    push(1'b1, se, 1'b0, 1'b0);
    drive(b);
  endtask

  task automatic send_rt(input logic [7:0] b);
    last_rt = b;
    push(1'b0, 1'b0, 1'b1, 1'b0);
    drive(b);
  endtask

  task automatic send_drop(input logic [7:0] b);
    push(1'b0, 1'b0, 1'b0, 1'b1);
    drive(b);
  endtask

  task automatic send_quiet(input logic [7:0] b, input logic clr);
    if (clr) begin last_cur = 1'b0; last_cur_o = 1'b0; last_syx = 1'b0; end
    drive(b);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".byteready"}, 8'(byteready), 8'h00);
    check({tag, ".data"}, data, 8'h00);
    check({tag, ".nr"}, nr, 8'h00);
    check({tag, ".cur"}, 8'(is_cur), 8'h00);
    check({tag, ".syx"}, 8'(is_syx), 8'h00);
    check({tag, ".syx_end"}, 8'(syx_end), 8'h00);
    check({tag, ".rt_valid"}, 8'(rt_valid), 8'h00);
    check({tag, ".rt_byte"}, rt_byte, 8'h00);
    check({tag, ".drop"}, 8'(drop), 8'h00);
    check({tag, ".omni_cur"}, 8'(o_is_cur), 8'h00);
  endtask

  task automatic do_reset();
    @(negedge reg_clk);
    rx_valid  = 1'b0;
    reset_reg = 1'b1;
    last_data = 8'h00; last_nr = 8'h00; last_rt = 8'h00;
    last_cur = 1'b0; last_cur_o = 1'b0; last_syx = 1'b0;
    @(negedge reg_clk);
    check_all_zero("reset");
    reset_reg = 1'b0;
  endtask

  // Pop one expectation per output event and compare every observable field.
  always @(negedge reg_clk) begin
    if (!reset_reg && (byteready || drop || rt_valid || syx_end || o_byteready)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL unexpected_event: observed data=%0h br=%0b drop=%0b rt=%0b se=%0b expected none",
               data, byteready, drop, rt_valid, syx_end);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("byteready", 8'(byteready), 8'(e.br));
        check("omni_byteready", 8'(o_byteready), 8'(e.br));
        check("midi_in_data", data, e.data);
        check("midibyte_nr", nr, e.nr);
        check("is_cur_midi_ch", 8'(is_cur), 8'(e.cur));
        check("omni_is_cur_midi_ch", 8'(o_is_cur), 8'(e.cur_o));
        check("is_st_sysex", 8'(is_syx), 8'(e.syx));
        check("syx_end", 8'(syx_end), 8'(e.se));
        check("rt_valid", 8'(rt_valid), 8'(e.rt));
        check("rt_byte", rt_byte, e.rtb);
        check("drop", 8'(drop), 8'(e.drop));
      end
    end
  end

  initial begin
    repeat (2) @(negedge reg_clk);
    check_all_zero("init");
    reset_reg = 1'b0;

    // Note-on on channel 0 with running status
    ch_sel = 4'd0;
    send_emit(8'h90, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_emit(8'h3C, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_emit(8'h64, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    send_emit(8'h3C, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_emit(8'h00, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    // Other channel: only the omni instance qualifies it
    send_emit(8'h91, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_emit(8'h3C, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_emit(8'h64, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);

    // SysEx with an embedded real-time byte
    send_emit(8'hF0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1 & 1'b0);
    send_emit(8'h43, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_emit(8'h10, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    send_rt(8'hF8);
    send_emit(8'h7F, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    send_emit(8'hF7, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // SysEx cut short by a channel status
    send_emit(8'hF0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_emit(8'h01, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_emit(8'h90, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    send_emit(8'h40, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Stray F7 is ignored; running status survives; RT between data bytes
    send_quiet(8'hF7, 1'b0);
    send_emit(8'h41, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    send_rt(8'hFE);
    send_emit(8'h42, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    idle();

    // After reset: data drops, one-byte message numbering, system common swallow
    do_reset();
    send_drop(8'h3C);
    ch_sel = 4'd2;
    send_emit(8'hC2, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_emit(8'h05, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_emit(8'h06, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_quiet(8'hF2, 1'b1);
    send_quiet(8'h00, 1'b0);
    send_quiet(8'h10, 1'b0);
    send_drop(8'h40);
    idle();
    @(negedge reg_clk);
    check("syscom.cur_cleared", 8'(is_cur), 8'h00);
    check("syscom.data_held", data, 8'h06);

    // midi_ch change mid-message; F6 clears running status
    ch_sel = 4'd3;
    send_emit(8'h93, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    ch_sel = 4'd0;
    send_emit(8'h11, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_quiet(8'hF6, 1'b1);
    send_drop(8'h22);

    // SysEx byte counter saturation
    send_emit(8'hF0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 260; i++)
      send_emit(8'(i & 8'h7F), (i > 255) ? 8'hFF : 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    send_emit(8'hF7, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    idle();

    // Reset aborts a message in progress
    send_emit(8'h90, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_emit(8'h3C, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    do_reset();
    send_drop(8'h64);
    idle();

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge reg_clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_in_parser.md
# midi_in_parser

Byte-level MIDI stream parser feeding the synth controller's sequencer trigger stage. Takes raw received bytes from the MIDI UART, tracks running status, numbers the bytes of each channel/SysEx message and qualifies them by channel. Produces the `byteready` / `midibyte_nr` / `midi_in_data` / `is_cur_midi_ch` / `is_st_sysex` set consumed by `seq_trigger`; real-time bytes are split off on a separate strobe.

## Interface
Clock is `reg_clk`; reset is asynchronous, active-high `reset_reg`.

Parameters:
- `OMNI`, 0, 1 = every channel message qualifies as current channel
- `SYX_NR_MAX`, 8'hFF, saturation value of the SysEx byte counter

Ports:
- `reg_clk`  in  1  system register clock
- `reset_reg`  in  1  async active-high reset
- `rx_valid`  in  1  one-cycle strobe: `rx_byte` holds a new received byte
- `rx_byte`  in  8  received MIDI byte
- `midi_ch`  in  4  selected MIDI channel (0–15)
- `byteready`  out  1  one-cycle strobe: outputs below describe a new message byte
- `midi_in_data`  out  8  the byte, status or data
- `midibyte_nr`  out  8  position in message: 0 = status, 1.. = data
- `is_cur_midi_ch`  out  1  current message is a channel message for `midi_ch`
- `is_st_sysex`  out  1  current byte belongs to a SysEx (F0..F7 inclusive)
- `syx_end`  out  1  one-cycle strobe: SysEx terminated (F7 or interrupting status)
- `rt_valid`  out  1  one-cycle strobe: real-time byte F8–FF on `rt_byte`
- `rt_byte`  out  8  last real-time byte
- `drop`  out  1  one-cycle strobe: data byte discarded (no running status)

## Operation
- States: IDLE (no running status), CHAN (channel running status), SYSEX, SYSCOM (F1/F2/F3 pending data).
- Data length `len`: 8x/9x/Ax/Bx/Ex = 2, Cx/Dx = 1, F1/F3 = 1, F2 = 2, F6 = 0.
- Channel status 80–EF: any state → CHAN; latch status; emit byte with nr 0; `is_cur_midi_ch` = OMNI | (status[3:0] == midi_ch).
- Data byte in CHAN: nr = previous nr + 1. After nr reaches `len`, next data byte is nr 1 (running status). Note-on data therefore numbers 1, 2, 1, 2…
- F0: → SYSEX; emit nr 0, `is_st_sysex` = 1. Data bytes nr 1, 2, … saturating at SYX_NR_MAX.
- F7 in SYSEX: emit with nr 0, `is_st_sysex` = 1, pulse `syx_end`; → IDLE. F7 outside SYSEX: ignored, no strobe.
- Any other non-RT status in SYSEX: pulse `syx_end` in the same cycle as that status is processed normally.
- F1–F6: clear running status. Not emitted on `byteready`; `is_cur_midi_ch` and `is_st_sysex` → 0. F1/F2/F3 → SYSCOM, whose data bytes are consumed silently, then → IDLE. F4/F5/F6 → IDLE.
- F8–FF: `rt_valid`/`rt_byte` only; state, counters and all `byteready`-side outputs unchanged. Valid inside SysEx and between data bytes.
- Data byte in IDLE: pulse `drop`, nothing else.
- `midi_ch` is re-sampled on every emitted byte; a change mid-stream takes effect on the next emitted byte.

## Timing
- All outputs registered. Byte on `rx_valid` at cycle N → strobes and data at N+1.
- Back-to-back `rx_valid` on consecutive cycles is supported; one byte processed per cycle, no backpressure.
- `midi_in_data`, `midibyte_nr`, `is_cur_midi_ch`, `is_st_sysex` hold between strobes.
- Reset values: all strobes 0; `midi_in_data`, `midibyte_nr`, `rt_byte` = 8'h00; `is_cur_midi_ch`, `is_st_sysex` = 0. State IDLE, counter 0, running status cleared.
- Reset mid-message aborts it. No `syx_end` is issued for an aborted SysEx.

## Structure
- Shared package `midi_pkg`: status constants (NOTE_OFF 8'h80 … SYX_END 8'hF7, RT_MIN 8'hF8), state enum `midi_rx_state_t`, and function `midi_data_len(status)` returning 0–2. `seq_trigger` may reuse it.
- Single module; no sub-module needed.

## Test plan
- Bytes 90 3C 64 3C 00 with midi_ch = 0 → byteready ×5, nr 0,1,2,1,2, is_cur_midi_ch = 1 throughout.
- Bytes 91 3C 64 with midi_ch = 0 → same numbering, is_cur_midi_ch = 0. Repeat with OMNI = 1 → 1.
- Bytes F0 43 10 F8 7F F7 → nr 0,1,2,3,0, is_st_sysex = 1. F8 gives rt_valid only; syx_end on the F7 cycle.
- Bytes F0 01 90 40 → syx_end with the 90; then nr 0,1, is_st_sysex = 0.
- After reset: 3C → drop; C2 05 06 (midi_ch = 2) → nr 0,1,1. Then F2 00 10 40 → no byteready for the F2 and its data, drop on 40.
- Assert reset during 90 3C → all outputs 0 next cycle. Then 64 → drop.
